ifft_butterfly_split: RTL
=========================

Name: ifft_butterfly_split

Overview:
- Streaming inverse radix-2 butterfly: the split that undoes the FFT combine stage.
- Takes one frequency-domain pair (X[k], X[k+N/2]) and one twiddle W[k] per transfer.
- Produces even[k] = (X+Y)/2 and odd[k] = ((X−Y)/2)·conj(W).
- Sits at the head of the IFFT path, feeding resynthesis of processed audio buffers. Processes one pair per clock through a 3-stage pipeline with valid/ready on both sides.

Parameters:
twiddle_size, 16, twiddle width; format signed Q1.(twiddle_size−1)
sample_size, 32, signed width of each real/imag sample component
buffer_size, 32, FFT length N; a frame is N/2 pairs; power of two ≥ 4

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input pair valid
in_ready  out  1  block can accept the pair this cycle
sum_real  in  sample_size  Re X[k]
sum_imag  in  sample_size  Im X[k]
diff_real  in  sample_size  Re X[k+N/2]
diff_imag  in  sample_size  Im X[k+N/2]
twiddle_real  in  twiddle_size  Re W[k]
twiddle_imag  in  twiddle_size  Im W[k]
out_valid  out  1  output pair valid
out_ready  in  1  downstream accepts
even_real  out  sample_size  Re even[k]
even_imag  out  sample_size  Im even[k]
odd_real  out  sample_size  Re odd[k]
odd_imag  out  sample_size  Im odd[k]
out_index  out  $clog2(buffer_size/2)  k of the current output
out_last  out  1  asserted with k = N/2−1
frame_done  out  1  single-cycle pulse after the last pair of a frame transfers

Behaviour:
- Reset is asynchronous, asserted while rst_n = 0. All stage valid bits, data registers, out_index, out_last and frame_done clear to 0. Consequently in_ready = 1 during reset, since out_valid = 0.
- Pipeline enable: adv = !out_valid || out_ready. in_ready = adv, driven combinationally.
- Input transfer occurs when in_valid && in_ready. All registers advance only when adv = 1. Stage valid bits shift with the data, so bubbles propagate.
- Latency: 3 cycles from accepted input to out_valid, with no stalls. Throughput: 1 pair per cycle.
- While out_valid && !out_ready, all outputs hold stable.
- S1:
  - Compute X+Y and X−Y at sample_size+1 bits.
  - Halve by arithmetic shift right 1 (floor).
  - Result fits sample_size, so there is no overflow.
  - The even result is final here.
  - Register the even result, diff/2, and the twiddle.
- S2: complex multiply by conj(W).
  - re = dr·wr + di·wi
  - im = di·wr − dr·wi
  - Products are sample_size+twiddle_size bits; sums are one bit wider.
  - Registered at full width.
- S3: round half-up and scale.
  - Add 2^(twiddle_size−2), then arithmetic shift right (twiddle_size−1).
  - Reduce to sample_size bits as defined by the optional feature.
  - Register the outputs.
- Index counter:
  - Counts output transfers (out_valid && out_ready) from 0 to N/2−1, then wraps to 0.
  - out_index shows the count; out_last = (count == N/2−1) && out_valid.
  - frame_done pulses 1 cycle after the transfer where out_last = 1.
- Reset mid-frame discards in-flight pairs and restarts the index at 0.
- No input-side frame marker: the frame is defined by output count only.

Optional Feature:
- Macro: IFFT_SPLIT_SAT_EN.
- Defined: the S3 result saturates to [−2^(sample_size−1), 2^(sample_size−1)−1].
- Undefined: the S3 result is truncated to its low sample_size bits (two's-complement wrap).
- Even path never overflows; the macro has no effect there.

Decomposition:
- Shared package fft_pkg:
  - sample, twiddle and product typedefs derived from the parameters
  - ROUND_CONST, TW_FRAC_BITS
  - saturation function
- One natural sub-module, fft_cmul_conj: the S2 conj-multiply plus the S3 round/scale/saturate, as a 2-register-stage pipeline with an enable input.

Test Plan:
- Basic split, defaults: X=1000, Y=200, W=(32767,0) → even=(600,0), odd=(400,0) on the 3rd cycle after acceptance.
- Quarter twiddle: X=1000, Y=200, W=(0,−32768) → even=(600,0), odd=(0,400).
- Floor halving: X=(−2^31,−2^31), Y=(2^31−1,2^31−1), W=(−32768,−32768).
  - Even = (0xFFFFFFFF, 0xFFFFFFFF).
  - Odd real = 0x7FFFFFFF with IFFT_SPLIT_SAT_EN, 0x00000000 without.
  - Odd imag = 0.
- Backpressure: stream 16 pairs with out_ready toggling every 2 cycles.
  - No loss or duplication.
  - Outputs stable while stalled.
  - in_ready = 0 only when out_valid && !out_ready.
- Frame: 16 consecutive transfers.
  - out_index steps 0..15.
  - out_last only with index 15.
  - frame_done pulses once, 1 cycle later.
  - The next pair shows index 0.
- Reset mid-frame: assert rst_n = 0 after 5 outputs with 2 pairs in flight.
  - out_valid = 0 immediately (asynchronous).
  - After release, the first new output has out_index = 0, and no stale pair emerges.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and constants for the IFFT split datapath.
// Widths are fixed here; the block parameters default to these values and
// must match them.
//   sample_t  : signed real/imag sample component
//   twiddle_t : signed Q1.(TWIDDLE_SIZE-1) twiddle component
//   product_t : sample x twiddle product
//   acc_t     : sum of two products (one guard bit)
package fft_pkg;

  localparam int unsigned SAMPLE_SIZE  = 32;
  localparam int unsigned TWIDDLE_SIZE = 16;
  localparam int unsigned BUFFER_SIZE  = 32;

  localparam int unsigned TW_FRAC_BITS = TWIDDLE_SIZE - 1;
  localparam int unsigned PRODUCT_SIZE = SAMPLE_SIZE + TWIDDLE_SIZE;

  typedef logic signed [SAMPLE_SIZE-1:0]  sample_t;
  typedef logic signed [TWIDDLE_SIZE-1:0] twiddle_t;
  typedef logic signed [PRODUCT_SIZE-1:0] product_t;
  typedef logic signed [PRODUCT_SIZE:0]   acc_t;

  // Half an LSB of the Q1.15 scaled result: round half-up before the shift.
  localparam acc_t ROUND_CONST = acc_t'(64'd1 << (TWIDDLE_SIZE - 2));

  localparam acc_t SAMPLE_MAX = acc_t'({1'b0, {(SAMPLE_SIZE-1){1'b1}}});
  localparam acc_t SAMPLE_MIN = -SAMPLE_MAX - acc_t'(1);

  // Clamp a scaled accumulator value to the sample range.
  function automatic sample_t sat_sample(input acc_t v);
    if (v > SAMPLE_MAX)      return sample_t'(SAMPLE_MAX);
    else if (v < SAMPLE_MIN) return sample_t'(SAMPLE_MIN);
    else                     return sample_t'(v);
  endfunction

endpackage

// File: rtl/ifft_butterfly_split_if.sv
// Handshake and data bus of the IFFT split block.
//   slave  : view of the block (accepts pairs, produces results)
//   master : view of the upstream/downstream environment
interface ifft_butterfly_split_if #(
  parameter int unsigned twiddle_size = fft_pkg::TWIDDLE_SIZE,
  parameter int unsigned sample_size  = fft_pkg::SAMPLE_SIZE,
  parameter int unsigned buffer_size  = fft_pkg::BUFFER_SIZE
);

  logic                                in_valid;
  logic                                in_ready;
  logic signed [sample_size-1:0]       sum_real;
  logic signed [sample_size-1:0]       sum_imag;
  logic signed [sample_size-1:0]       diff_real;
  logic signed [sample_size-1:0]       diff_imag;
  logic signed [twiddle_size-1:0]      twiddle_real;
  logic signed [twiddle_size-1:0]      twiddle_imag;
  logic                                out_valid;
  logic                                out_ready;
  logic signed [sample_size-1:0]       even_real;
  logic signed [sample_size-1:0]       even_imag;
  logic signed [sample_size-1:0]       odd_real;
  logic signed [sample_size-1:0]       odd_imag;
  logic [$clog2(buffer_size/2)-1:0]    out_index;
  logic                                out_last;
  logic                                frame_done;

  modport slave (
    input  in_valid, sum_real, sum_imag, diff_real, diff_imag,
           twiddle_real, twiddle_imag, out_ready,
    output in_ready, out_valid, even_real, even_imag, odd_real, odd_imag,
           out_index, out_last, frame_done
  );

  modport master (
    output in_valid, sum_real, sum_imag, diff_real, diff_imag,
           twiddle_real, twiddle_imag, out_ready,
    input  in_ready, out_valid, even_real, even_imag, odd_real, odd_imag,
           out_index, out_last, frame_done
  );

endinterface

// File: rtl/fft_cmul_conj.sv
// Multiply by conj(W), then round half-up and rescale to sample width.
// Two register stages, both advancing only when en = 1.
//   dr/di   : (X-Y)/2 real/imag
//   wr/wi   : twiddle W real/imag, Q1.15
//   odd_re/odd_im : ((X-Y)/2)*conj(W), registered
// Optional build macro IFFT_SPLIT_SAT_EN: saturate the rescaled result
// instead of wrapping it to the low sample bits.
module fft_cmul_conj
  import fft_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     en,
  input  sample_t  dr,
  input  sample_t  di,
  input  twiddle_t wr,
  input  twiddle_t wi,
  output sample_t  odd_re,
  output sample_t  odd_im
);

  product_t p_rr, p_ii, p_ir, p_ri;
  acc_t     re_n, im_n;
  acc_t     re_q, im_q;
  acc_t     re_rnd, im_rnd;

  always_comb begin
    p_rr = product_t'(dr) * product_t'(wr);
    p_ii = product_t'(di) * product_t'(wi);
    p_ir = product_t'(di) * product_t'(wr);
    p_ri = product_t'(dr) * product_t'(wi);
    re_n = acc_t'(p_rr) + acc_t'(p_ii);
    im_n = acc_t'(p_ir) - acc_t'(p_ri);
  end

  always_comb begin
    re_rnd = re_q + ROUND_CONST;
    im_rnd = im_q + ROUND_CONST;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      re_q   <= '0;
      im_q   <= '0;
      odd_re <= '0;
      odd_im <= '0;
    end else if (en) begin
      re_q <= re_n;
      im_q <= im_n;
`ifdef IFFT_SPLIT_SAT_EN
      odd_re <= sat_sample(re_rnd >>> TW_FRAC_BITS);
      odd_im <= sat_sample(im_rnd >>> TW_FRAC_BITS);
`else
      odd_re <= sample_t'(re_rnd >>> TW_FRAC_BITS);
      odd_im <= sample_t'(im_rnd >>> TW_FRAC_BITS);
`endif
    end
  end

endmodule

// File: rtl/ifft_butterfly_split.sv
// Streaming inverse radix-2 butterfly split:
//   even = (X+Y)/2, odd = ((X-Y)/2)*conj(W), 3-stage pipeline, 1 pair/clock.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : ifft_butterfly_split_if.slave -- input pair + twiddle with
//                in_valid/in_ready, results with out_valid/out_ready,
//                out_index/out_last (k within the frame of N/2 pairs) and a
//                one-cycle frame_done after the last pair transfers.
// Optional build macro IFFT_SPLIT_SAT_EN (in fft_cmul_conj): saturate odd.
// Widths are taken from fft_pkg; parameters must match the package.
module ifft_butterfly_split
  import fft_pkg::*;
#(
  parameter int unsigned twiddle_size = TWIDDLE_SIZE,
  parameter int unsigned sample_size  = SAMPLE_SIZE,
  parameter int unsigned buffer_size  = BUFFER_SIZE
) (
  input logic clk,
  input logic rst_n,
  ifft_butterfly_split_if.slave bus
);

  localparam int unsigned xw    = sample_size + 1;
  localparam int unsigned idx_w = $clog2(buffer_size / 2);
  localparam logic [idx_w-1:0] idx_max = idx_w'(buffer_size / 2 - 1);

  logic adv;
  logic v1, v2, v3;
  logic signed [xw-1:0]           sr_w, si_w, dr_w, di_w;
  logic signed [sample_size-1:0]  er1, ei1, er2, ei2, er3, ei3;
  logic signed [sample_size-1:0]  dr1, di1;
  logic signed [twiddle_size-1:0] wr1, wi1;
  logic [idx_w-1:0]               cnt;
  logic                           fdone;
  logic                           out_fire;

  // The whole pipeline stalls only when a result is held at the output.
  assign adv      = !v3 || bus.out_ready;
  assign out_fire = v3 && bus.out_ready;

  always_comb begin
    sr_w = xw'(bus.sum_real) + xw'(bus.diff_real);
    si_w = xw'(bus.sum_imag) + xw'(bus.diff_imag);
    dr_w = xw'(bus.sum_real) - xw'(bus.diff_real);
    di_w = xw'(bus.sum_imag) - xw'(bus.diff_imag);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      v3    <= 1'b0;
      er1   <= '0;
      ei1   <= '0;
      er2   <= '0;
      ei2   <= '0;
      er3   <= '0;
      ei3   <= '0;
      dr1   <= '0;
      di1   <= '0;
      wr1   <= '0;
      wi1   <= '0;
      cnt   <= '0;
      fdone <= 1'b0;
    end else begin
      if (adv) begin
        v1  <= bus.in_valid;
        // Arithmetic shift of the widened sum halves with floor; the result
        // always fits back into sample_size bits.
        er1 <= sample_size'(sr_w >>> 1);
        ei1 <= sample_size'(si_w >>> 1);
        dr1 <= sample_size'(dr_w >>> 1);
        di1 <= sample_size'(di_w >>> 1);
        wr1 <= bus.twiddle_real;
        wi1 <= bus.twiddle_imag;
        v2  <= v1;
        er2 <= er1;
        ei2 <= ei1;
        v3  <= v2;
        er3 <= er2;
        ei3 <= ei2;
      end
      if (out_fire) cnt <= (cnt == idx_max) ? '0 : cnt + idx_w'(1);
      fdone <= out_fire && (cnt == idx_max);
    end
  end

  fft_cmul_conj u_cmul (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (adv),
    .dr     (dr1),
    .di     (di1),
    .wr     (wr1),
    .wi     (wi1),
    .odd_re (bus.odd_real),
    .odd_im (bus.odd_imag)
  );

  assign bus.in_ready   = adv;
  assign bus.out_valid  = v3;
  assign bus.even_real  = er3;
  assign bus.even_imag  = ei3;
  assign bus.out_index  = cnt;
  assign bus.out_last   = v3 && (cnt == idx_max);
  assign bus.frame_done = fdone;

endmodule
